ram_sink: RTL and testbench
===========================

# ram_sink

Write-side consumer for the packet-decode stage's RAM interface (`ram_en`/`ram_address`/`ram_data`/`error`). It commits error-free writes into a 256×16 storage array and tracks which addresses have been written. It also counts rejected writes and serves a one-cycle-latency read port to the checker/host. After reset, and on request, a clear sequencer wipes the array before writes are accepted.

## Interface
- `ADDR_W`, 8: address width; depth = 2^ADDR_W.
- `DATA_W`, 16: data width.
- `CNT_W`, 8: width of the saturating counters.

- `clk`  in  1  single clock; all flops update on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it immediately forces all state to reset values.
- `ram_en`  in  1  write strobe from the upstream stage.
- `ram_address`  in  ADDR_W  write address.
- `ram_data`  in  DATA_W  write data.
- `error`  in  1  upstream error flag; qualifies the write in the same cycle.
- `clr`  in  1  one-cycle pulse that restarts the clear sequence.
- `rd_req`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address.
- `rd_valid`  out  1  read response strobe.
- `rd_data`  out  DATA_W  read data.
- `rd_hit`  out  1  read address was written since the last clear.
- `rd_perr`  out  1  parity mismatch on the read word (see Configuration).
- `busy`  out  1  clear sequence in progress.
- `err_count`  out  CNT_W  writes rejected because `error`=1.
- `drop_count`  out  CNT_W  writes dropped while `busy`.

## Operation
- **FSM states**
  - `CLEAR`: entered on reset deassertion and on `clr`; `busy`=1.
  - `IDLE`: `busy`=0.
- **CLEAR**
  - Internal pointer `cp` starts at 0.
  - Each cycle: `mem[cp]`←0, `wflag[cp]`←0, then `cp`++.
  - After `cp`=2^ADDR_W−1 is cleared: go to `IDLE`. Duration is exactly 2^ADDR_W cycles.
- **`clr` handling**
  - `clr` in `IDLE`: go to `CLEAR` with `cp`=0 next cycle.
  - `clr` in `CLEAR`: restarts `cp` at 0.
- **Write in IDLE** (`ram_en`=1):
  - `error`=0: `mem[ram_address]`←`ram_data` and `wflag[ram_address]`←1.
  - `error`=1: no commit; `err_count`++.
- **Write in CLEAR** (`ram_en`=1): no commit; `drop_count`++. This applies regardless of `error`; `err_count` is not touched.
- `ram_en`=0: `error` is ignored.
- **Counters**
  - Saturate at 2^CNT_W−1.
  - Cleared only by `reset`; `clr` does not clear them.
- **Read**
  - `rd_req`=1 in `IDLE`: next cycle `rd_valid`=1, `rd_data`=`mem[rd_addr]`, `rd_hit`=`wflag[rd_addr]`.
  - `rd_req` in `CLEAR` is ignored: no `rd_valid`.
- **Read/write collision** (same-cycle read and committed write to the same address): read returns the pre-write data and pre-write `wflag`.
- When `rd_valid`=0: `rd_data`, `rd_hit` and `rd_perr` hold their last values.

## Timing
- **Reset values:**
  - `busy`=1 (FSM in `CLEAR`, `cp`=0).
  - `rd_valid`=0, `rd_data`=0, `rd_hit`=0, `rd_perr`=0.
  - `err_count`=0, `drop_count`=0.
- **Reset behaviour:**
  - Storage contents are not reset directly; the `CLEAR` pass zeroes them.
  - Reset asserted mid-clear or mid-read aborts the operation. After deassertion a full `CLEAR` restarts from `cp`=0.
- **Clear timing:** the first write accepted is on cycle 2^ADDR_W after reset deassertion (256 for defaults), counting the first edge as cycle 0.
- **Read timing:**
  - Read latency is 1 cycle.
  - `rd_valid` is a single-cycle pulse per `rd_req` cycle.
  - Back-to-back requests give back-to-back responses.
- **Write commit:** a write accepted at edge N is visible to a read requested at edge N+1.
- **Clear boundary:** a request in the last `CLEAR` cycle is ignored; a request in the first `IDLE` cycle is served.

## Configuration
- **`RAM_SINK_PARITY_EN` defined:**
  - Each word stores an extra even-parity bit, computed as `^ram_data` on commit; `CLEAR` writes parity 0.
  - On read, `rd_perr`=1 when the stored parity ≠ `^mem data`; it updates with `rd_valid`.
- **`RAM_SINK_PARITY_EN` undefined:**
  - Storage is DATA_W bits.
  - `rd_perr` is constant 0.

## Test plan
- **Reset-clear window:** reset low 2 cycles, then high; write addr 0x05 data 0x1234 at cycle 10 → `drop_count`=1, `busy` falls at cycle 256. Read 0x05 → `rd_data`=0x0000, `rd_hit`=0.
- **Commit/readback:** in `IDLE`, write 0x3C←0xBEEF with `error`=0, then read 0x3C next cycle → `rd_valid`=1, `rd_data`=0xBEEF, `rd_hit`=1, `rd_perr`=0.
- **Rejected writes:** 300 writes with `error`=1 to 0x10 → `err_count`=255 (saturated); read 0x10 → `rd_hit`=0.
- **Collision:** 0x20 holds 0x1111; same cycle write 0x20←0x2222 and read 0x20 → `rd_data`=0x1111; next read → 0x2222.
- **`clr` mid-traffic and reset mid-clear:**
  - Pulse `clr` after several writes → `busy` high 256 cycles; reads then give `rd_hit`=0, `rd_data`=0; counters unchanged.
  - Assert reset at clear cycle 100 → after release, `busy` lasts a full 256 cycles.
- **Parity** (`RAM_SINK_PARITY_EN`): force the stored data bit 0 of addr 0x01 via hierarchical deposit after writing 0x0003; read → `rd_perr`=1.

Source files
------------

// File: rtl/ram_sink.sv
`default_nettype none
// ============================================================================
// Module      : ram_sink
// Description : Write-side consumer of the packet-decode RAM interface.
//               Commits error-free writes into a 2^ADDR_W x DATA_W array,
//               tracks written addresses, counts rejected/dropped writes,
//               and serves a 1-cycle-latency read port. A clear sequencer
//               zeroes the array after reset and on every clr pulse.
//               Optional: define RAM_SINK_PARITY_EN to store an even-parity
//               bit per word and report mismatches on rd_perr.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sink #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ram_en,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic [DATA_W-1:0] ram_data,
   input  logic              error,
   input  logic              clr,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_hit,
   output logic              rd_perr,
   output logic              busy,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_SINK_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] c_cp_last = '1;
   localparam logic [ADDR_W-1:0] c_cp_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  c_cnt_max = '1;
   localparam logic [CNT_W-1:0]  c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cp;
   logic [ADDR_W-1:0] w_cp_nxt;

   logic [MEM_W-1:0]  r_mem [DEPTH];
   logic [DEPTH-1:0]  r_wflag;

   logic              w_idle;
   logic              w_commit;
   logic              w_rd_fire;
   logic [MEM_W-1:0]  w_wr_word;
   logic [MEM_W-1:0]  w_rd_word;

   logic [CNT_W-1:0]  r_err_count;
   logic [CNT_W-1:0]  r_drop_count;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_hit;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_commit  = w_idle & ram_en & ~error;
   assign w_rd_fire = w_idle & rd_req;
   assign w_rd_word = r_mem[rd_addr];

`ifdef RAM_SINK_PARITY_EN
   assign w_wr_word = {^ram_data, ram_data};
`else
   assign w_wr_word = ram_data;
`endif

   // FSM state and clear-pointer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_CLEAR;
         r_cp    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cp    <= w_cp_nxt;
      end
   end

   // Next-state logic: walk the pointer across every address, restart on clr
   always_comb begin
      w_state_nxt = r_state;
      w_cp_nxt    = r_cp;
      case (r_state)
         ST_CLEAR: begin
            if (clr) begin
               w_cp_nxt = '0;
            end else if (r_cp == c_cp_last) begin
               w_state_nxt = ST_IDLE;
               w_cp_nxt    = '0;
            end else begin
               w_cp_nxt = r_cp + c_cp_one;
            end
         end
         ST_IDLE: begin
            if (clr) begin
               w_state_nxt = ST_CLEAR;
               w_cp_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cp_nxt    = '0;
         end
      endcase
   end

   // Storage: zeroed one word per cycle while clearing, otherwise commits writes
   always_ff @(posedge clk) begin
      if (!w_idle) begin
         r_mem[r_cp]   <= '0;
         r_wflag[r_cp] <= 1'b0;
      end else if (w_commit) begin
         r_mem[ram_address]   <= w_wr_word;
         r_wflag[ram_address] <= 1'b1;
      end
   end

   // Saturating counters for rejected and dropped writes; only reset clears them
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_count  <= '0;
         r_drop_count <= '0;
      end else begin
         if (ram_en && w_idle && error && (r_err_count != c_cnt_max))
            r_err_count <= r_err_count + c_cnt_one;
         if (ram_en && !w_idle && (r_drop_count != c_cnt_max))
            r_drop_count <= r_drop_count + c_cnt_one;
      end
   end

   // Read port: registered array read gives pre-write data on a collision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_fire;
         if (w_rd_fire) begin
            r_rd_data <= w_rd_word[DATA_W-1:0];
            r_rd_hit  <= r_wflag[rd_addr];
         end
      end
   end

`ifdef RAM_SINK_PARITY_EN
   logic r_rd_perr;

   // Parity check: stored parity bit against recomputed parity of stored data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_perr <= 1'b0;
      end else if (w_rd_fire) begin
         r_rd_perr <= w_rd_word[DATA_W] ^ (^w_rd_word[DATA_W-1:0]);
      end
   end

   assign rd_perr = r_rd_perr;
`else
   assign rd_perr = 1'b0;
`endif

   assign busy       = ~w_idle;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign rd_hit     = r_rd_hit;
   assign err_count  = r_err_count;
   assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_ram_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sink
// Description : Self-checking bench for ram_sink. A behavioural model keeps
//               the array contents, written flags, counters and the number
//               of clear cycles still outstanding; every cycle the DUT
//               outputs are compared against it. Parity section is built
//               only when RAM_SINK_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sink;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ram_en = 1'b0;
   logic [7:0]  ram_address = '0;
   logic [15:0] ram_data = '0;
   logic        error = 1'b0;
   logic        clr = 1'b0;
   logic        rd_req = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        rd_hit;
   logic        rd_perr;
   logic        busy;
   logic [7:0]  err_count;
   logic [7:0]  drop_count;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model
   logic [15:0] m_mem  [256];
   logic        m_flag [256];
   logic        m_pbad [256];
   int          m_clear_left;
   int          m_err;
   int          m_drop;
   logic        e_valid;
   logic [15:0] e_data;
   logic        e_hit;
   logic        e_perr;

   ram_sink #(.ADDR_W(8), .DATA_W(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .ram_en(ram_en), .ram_address(ram_address), .ram_data(ram_data),
      .error(error), .clr(clr),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_hit(rd_hit), .rd_perr(rd_perr),
      .busy(busy), .err_count(err_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wipe();
      for (int i = 0; i < 256; i++) begin
         m_mem[i]  = '0;
         m_flag[i] = 1'b0;
         m_pbad[i] = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("busy",       {31'd0, busy},       {31'd0, (m_clear_left != 0)});
      chk("err_count",  {24'd0, err_count},  m_err);
      chk("drop_count", {24'd0, drop_count}, m_drop);
      chk("rd_valid",   {31'd0, rd_valid},   {31'd0, e_valid});
      chk("rd_data",    {16'd0, rd_data},    {16'd0, e_data});
      chk("rd_hit",     {31'd0, rd_hit},     {31'd0, e_hit});
      chk("rd_perr",    {31'd0, rd_perr},    {31'd0, e_perr});
   endtask

   // one clock cycle: drive, advance the model at the edge, check after it
   task automatic cyc(input logic en, input logic [7:0] a, input logic [15:0] d,
                      input logic er, input logic cl, input logic rq,
                      input logic [7:0] ra);
      logic idle;
      ram_en = en; ram_address = a; ram_data = d; error = er;
      clr = cl; rd_req = rq; rd_addr = ra;
      @(posedge clk);
      idle = (m_clear_left == 0);
      if (rq && idle) begin
         e_valid = 1'b1;
         e_data  = m_mem[ra];
         e_hit   = m_flag[ra];
         e_perr  = m_pbad[ra];
      end else begin
         e_valid = 1'b0;
      end
      if (en) begin
         if (!idle) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
         else if (er) m_err = (m_err < 255) ? m_err + 1 : 255;
         else begin
            m_mem[a]  = d;
            m_flag[a] = 1'b1;
            m_pbad[a] = 1'b0;
         end
      end
      if (cl) begin
         wipe();
         m_clear_left = 256;
      end else if (!idle) begin
         m_clear_left--;
      end
      #1;
      check_all();
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      ram_en = 1'b0; error = 1'b0; clr = 1'b0; rd_req = 1'b0;
      reset = 1'b0;
      wipe();
      m_clear_left = 256;
      m_err = 0; m_drop = 0;
      e_valid = 1'b0; e_data = '0; e_hit = 1'b0; e_perr = 1'b0;
      #1;
      check_all();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      // reset and reset-clear window
      do_reset();
      for (int i = 0; i < 257; i++) begin
         if (i == 10)
            cyc(1'b1, 8'h05, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00);
         else
            cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, (i >= 250), 8'h05);
      end
      chk("win_drop", {24'd0, drop_count}, 32'd1);
      chk("win_busy", {31'd0, busy}, 32'd0);
      chk("win_rdata", {16'd0, rd_data}, 32'h0000);
      chk("win_rhit", {31'd0, rd_hit}, 32'd0);

      // commit and readback
      cyc(1'b1, 8'h3C, 16'hBEEF, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h3C);
      chk("rb_valid", {31'd0, rd_valid}, 32'd1);
      chk("rb_data", {16'd0, rd_data}, 32'hBEEF);
      chk("rb_hit", {31'd0, rd_hit}, 32'd1);
      idle_cyc();
      chk("rb_pulse", {31'd0, rd_valid}, 32'd0);

      // rejected writes saturate err_count
      for (int i = 0; i < 300; i++)
         cyc(1'b1, 8'h10, 16'($urandom), 1'b1, 1'b0, 1'b0, 8'h00);
      chk("err_sat", {24'd0, err_count}, 32'd255);
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h10);
      chk("rej_hit", {31'd0, rd_hit}, 32'd0);

      // read/write collision
      cyc(1'b1, 8'h20, 16'h1111, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 8'h20, 16'h2222, 1'b0, 1'b0, 1'b1, 8'h20);
      chk("coll_old", {16'd0, rd_data}, 32'h1111);
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h20);
      chk("coll_new", {16'd0, rd_data}, 32'h2222);

      // randomized traffic over a small address window
      for (int i = 0; i < 300; i++)
         cyc(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 15)), 16'($urandom),
             ($urandom_range(0, 3) == 0), 1'b0, 1'($urandom), 8'($urandom_range(0, 15)));

      // clr mid-traffic: writes during the clear are dropped
      cyc(1'b1, 8'h07, 16'hA5A5, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 256; i++)
         cyc(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 15)), 16'($urandom),
             1'($urandom), 1'b0, 1'($urandom), 8'($urandom_range(0, 15)));
      chk("clr_done", {31'd0, busy}, 32'd0);
      for (int a = 0; a < 16; a++) begin
         cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'(a));
         chk("clr_rhit", {31'd0, rd_hit}, 32'd0);
         chk("clr_rdata", {16'd0, rd_data}, 32'h0000);
      end

      // clr issued while already clearing restarts the walk
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 50; i++) idle_cyc();
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 260; i++)
         cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h3C);

      // reset in the middle of a clear pass
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 100; i++) idle_cyc();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         chk("rst_busy", {31'd0, busy}, 32'd1);
         cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      chk("rst_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom), 8'($urandom_range(0, 7)), 16'($urandom),
             ($urandom_range(0, 3) == 0), 1'b0, 1'($urandom), 8'($urandom_range(0, 7)));

`ifdef RAM_SINK_PARITY_EN
      // corrupt a stored bit behind the design's back
      cyc(1'b1, 8'h01, 16'h0003, 1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h01);
      chk("par_clean", {31'd0, rd_perr}, 32'd0);
      dut.r_mem[1] = 17'h0_0002;
      m_mem[1]  = 16'h0002;
      m_pbad[1] = 1'b1;
      cyc(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h01);
      chk("par_err", {31'd0, rd_perr}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
